// File: rtl/ccff_loader_pkg.sv
// Shared types and constants for the configuration-chain bitstream loader.
// The CRC step helper is the single definition used by the serial CRC block.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StWait,
    StDone
  } ld_state_e;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // CRC-16/CCITT, one bit per call, MSB-first.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    crc16_step = {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/ccff_crc16_serial.sv
// Bit-serial CRC-16/CCITT accumulator with enable and synchronous init.
// Init takes priority over a simultaneous enabled bit.
module ccff_crc16_serial
  import ccff_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        init_i,
  input  logic        en_i,
  input  logic        bit_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init_i) begin
      crc_d = CRC_INIT;
    end else if (en_i) begin
      crc_d = crc16_step(crc_q, bit_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Word-to-serial loader for the fabric configuration chain: shifts chain_len bits into
// ccff_head, gates the chain clock, holds I/O isolation and CRCs the displaced tail bits.
module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 20
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  chain_len,
  input  logic              word_valid,
  output logic              word_ready,
  input  logic [DATA_W-1:0] word_data,
  output logic              ccff_head,
  output logic              chain_clk_en,
  input  logic              ccff_tail,
  output logic              io_isol_n,
  output logic              busy,
  output logic              done,
  output logic [15:0]       tail_crc
);

  localparam int unsigned      SCntW    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] WordBits = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
  localparam logic [SCntW-1:0] SCntOne  = SCntW'(1);
  localparam logic [SCntW-1:0] SCntLoad = SCntW'(DATA_W - 1);

  ld_state_e         state_q, state_d;
  logic [CNT_W-1:0]  bits_left_q, bits_left_d;
  logic [CNT_W-1:0]  bits_req_q, bits_req_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [SCntW-1:0]  shift_cnt_q, shift_cnt_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_vld_q, hold_vld_d;
  logic              head_q, head_d;
  logic              clk_en_q, clk_en_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              isol_n_q, isol_n_d;
  logic              crc_init;
  logic              advance;
  logic              hs;
  logic [CNT_W-1:0]  take;

  assign hs   = word_valid & ready_q;
  assign take = (bits_req_q > WordBits) ? WordBits : bits_req_q;

  // The registered head/enable describe the bit the chain samples during the next cycle,
  // so a bit is drawn from the buffers at the edge that opens its shift cycle.
  always_comb begin
    state_d     = state_q;
    bits_left_d = bits_left_q;
    bits_req_d  = bits_req_q;
    shift_d     = shift_q;
    shift_cnt_d = shift_cnt_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    head_d      = head_q;
    clk_en_d    = 1'b0;
    done_d      = done_q;
    isol_n_d    = isol_n_q;
    crc_init    = 1'b0;
    advance     = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          bits_left_d = chain_len;
          bits_req_d  = chain_len;
          shift_cnt_d = '0;
          hold_vld_d  = 1'b0;
          crc_init    = 1'b1;
          if (chain_len == '0) begin
            state_d  = StDone;
            done_d   = 1'b1;
            isol_n_d = 1'b1;
          end else begin
            state_d  = StWait;
            done_d   = 1'b0;
            isol_n_d = 1'b0;
          end
        end
      end
      StShift, StWait: begin
        if (hs) begin
          bits_req_d = bits_req_q - take;
        end
        if (bits_left_q == '0) begin
          state_d     = StDone;
          done_d      = 1'b1;
          isol_n_d    = 1'b1;
          shift_cnt_d = '0;
          hold_vld_d  = 1'b0;
        end else begin
          if (shift_cnt_q != '0) begin
            head_d      = shift_q[0];
            shift_d     = shift_q >> 1;
            shift_cnt_d = shift_cnt_q - SCntOne;
            advance     = 1'b1;
            if (hs) begin
              hold_d     = word_data;
              hold_vld_d = 1'b1;
            end
          end else if (hold_vld_q) begin
            head_d      = hold_q[0];
            shift_d     = hold_q >> 1;
            shift_cnt_d = SCntLoad;
            hold_vld_d  = 1'b0;
            advance     = 1'b1;
          end else if (hs) begin
            // Both buffers empty: the arriving word bypasses the holding register.
            head_d      = word_data[0];
            shift_d     = word_data >> 1;
            shift_cnt_d = SCntLoad;
            advance     = 1'b1;
          end
          if (advance) begin
            clk_en_d    = 1'b1;
            bits_left_d = bits_left_q - CntOne;
            state_d     = StShift;
          end else begin
            state_d = StWait;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Chain contents are undefined after a cancel, so isolation stays asserted.
    if (abort) begin
      state_d     = StIdle;
      bits_left_d = '0;
      bits_req_d  = '0;
      shift_cnt_d = '0;
      hold_vld_d  = 1'b0;
      clk_en_d    = 1'b0;
      done_d      = 1'b0;
      isol_n_d    = 1'b0;
      crc_init    = 1'b0;
    end

    busy_d  = (state_d == StShift) || (state_d == StWait);
    ready_d = busy_d && !hold_vld_d && (bits_req_d != '0);
  end

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q     <= StIdle;
      bits_left_q <= '0;
      bits_req_q  <= '0;
      shift_q     <= '0;
      shift_cnt_q <= '0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      head_q      <= 1'b0;
      clk_en_q    <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      isol_n_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bits_left_q <= bits_left_d;
      bits_req_q  <= bits_req_d;
      shift_q     <= shift_d;
      shift_cnt_q <= shift_cnt_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      head_q      <= head_d;
      clk_en_q    <= clk_en_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      isol_n_q    <= isol_n_d;
    end
  end

  ccff_crc16_serial u_crc (
    .clk_i  (prog_clk),
    .rst_ni (pReset_n),
    .init_i (crc_init),
    .en_i   (clk_en_q),
    .bit_i  (ccff_tail),
    .crc_o  (tail_crc)
  );

  assign word_ready   = ready_q;
  assign ccff_head    = head_q;
  assign chain_clk_en = clk_en_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign io_isol_n    = isol_n_q;

endmodule
